// File: rtl/mips_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | mips_pkg : shared MIPS pipeline widths and access-size encodings |
// | Revision : 1.0                                                   |
// +-----------------------------------------------------------------+
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [1:0] {
    SIZE_WORD = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_BYTE = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;
endpackage
`default_nettype wire

// File: rtl/mem_stage_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | mem_stage_if : EX->MEM inputs and MEM/WB outputs of mem_stage    |
// | Revision     : 1.0                                               |
// +-----------------------------------------------------------------+
interface mem_stage_if;
  import mips_pkg::*;

  logic              in_stall;
  logic              in_flush;
  logic              in_mem_read;
  logic              in_mem_write;
  logic              in_mem_to_reg;
  logic              in_reg_write;
  logic [1:0]        in_size;
  logic              in_unsigned;
  logic [REG_W-1:0]  in_write_back_destination;
  logic [DATA_W-1:0] in_address;
  logic [DATA_W-1:0] in_write_data;

  logic              mem_to_reg_out;
  logic              reg_write_out;
  logic [REG_W-1:0]  write_back_destination_out;
  logic [DATA_W-1:0] address_out;
  logic [DATA_W-1:0] read_data_out;
  logic              misaligned_out;

  modport master (
    output in_stall, in_flush, in_mem_read, in_mem_write, in_mem_to_reg,
           in_reg_write, in_size, in_unsigned, in_write_back_destination,
           in_address, in_write_data,
    input  mem_to_reg_out, reg_write_out, write_back_destination_out,
           address_out, read_data_out, misaligned_out
  );

  modport slave (
    input  in_stall, in_flush, in_mem_read, in_mem_write, in_mem_to_reg,
           in_reg_write, in_size, in_unsigned, in_write_back_destination,
           in_address, in_write_data,
    output mem_to_reg_out, reg_write_out, write_back_destination_out,
           address_out, read_data_out, misaligned_out
  );
endinterface
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | data_memory : word array, per-byte write enable, async read      |
// | Revision    : 1.0                                                |
// +-----------------------------------------------------------------+
module data_memory
  import mips_pkg::*;
#(
  parameter int MEM_DEPTH_WORDS = 1024
) (
  input  wire logic                               clk,
  input  wire logic [$clog2(MEM_DEPTH_WORDS)-1:0] i_word_idx,
  input  wire logic [3:0]                         i_byte_we,
  input  wire logic [DATA_W-1:0]                  i_write_data,
  output logic      [DATA_W-1:0]                  o_read_data
);
  logic [DATA_W-1:0] r_mem [MEM_DEPTH_WORDS];

  // Enable bit n controls bits 8n+7:8n, so bit 3 is the big-endian byte 0.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_byte_we[i]) r_mem[i_word_idx][8*i +: 8] <= i_write_data[8*i +: 8];
    end
  end

  assign o_read_data = r_mem[i_word_idx];
endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | mem_stage : MIPS data-memory access and MEM/WB pipeline register |
// | Revision  : 1.0                                                  |
// +-----------------------------------------------------------------+
module mem_stage
  import mips_pkg::*;
#(
  parameter int MEM_DEPTH_WORDS = 1024
) (
  input wire logic clk,
  input wire logic rst,
  mem_stage_if.slave bus
);
  localparam int c_AW = $clog2(MEM_DEPTH_WORDS);

  logic [1:0]        w_off;
  logic              w_is_half;
  logic              w_is_byte;
  logic              w_misaligned;
  logic              w_store;
  logic [3:0]        w_lane_en;
  logic [3:0]        w_byte_we;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_raw;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_load;

  assign w_off     = bus.in_address[1:0];
  assign w_is_half = (bus.in_size == SIZE_HALF);
  assign w_is_byte = (bus.in_size == SIZE_BYTE);

  assign w_misaligned = (bus.in_mem_read | bus.in_mem_write) &
                        (w_is_half ? w_off[0] : (!w_is_byte && w_off != 2'b00));

  // Reset is in the gate so no edge inside a reset window can write.
  assign w_store = bus.in_mem_write & !w_misaligned & !bus.in_stall &
                   !bus.in_flush & !rst;

  always_comb begin
    w_lane_en = 4'b1111;
    w_wdata   = bus.in_write_data;
    if (w_is_half) begin
      w_lane_en = w_off[1] ? 4'b0011 : 4'b1100;
      w_wdata   = {2{bus.in_write_data[15:0]}};
    end else if (w_is_byte) begin
      w_lane_en = 4'b1000 >> w_off;
      w_wdata   = {4{bus.in_write_data[7:0]}};
    end
  end

  assign w_byte_we = w_store ? w_lane_en : 4'b0000;

  data_memory #(.MEM_DEPTH_WORDS(MEM_DEPTH_WORDS)) u_mem (
    .clk          (clk),
    .i_word_idx   (bus.in_address[c_AW+1:2]),
    .i_byte_we    (w_byte_we),
    .i_write_data (w_wdata),
    .o_read_data  (w_raw)
  );

  always_comb begin
    w_byte = w_raw[7:0];
    case (w_off)
      2'd0:    w_byte = w_raw[31:24];
      2'd1:    w_byte = w_raw[23:16];
      2'd2:    w_byte = w_raw[15:8];
      default: w_byte = w_raw[7:0];
    endcase
  end

  assign w_half = w_off[1] ? w_raw[15:0] : w_raw[31:16];

  always_comb begin
    w_load = w_raw;
    if (bus.in_mem_read) begin
      if (w_misaligned)   w_load = '0;
      else if (w_is_byte) w_load = bus.in_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      else if (w_is_half) w_load = bus.in_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || bus.in_flush) begin
      bus.mem_to_reg_out             <= 1'b0;
      bus.reg_write_out              <= 1'b0;
      bus.write_back_destination_out <= '0;
      bus.address_out                <= '0;
      bus.read_data_out              <= '0;
      bus.misaligned_out             <= 1'b0;
    end else if (!bus.in_stall) begin
      bus.mem_to_reg_out             <= bus.in_mem_to_reg;
      bus.reg_write_out              <= bus.in_reg_write & !(bus.in_mem_read & w_misaligned);
      bus.write_back_destination_out <= bus.in_write_back_destination;
      bus.address_out                <= bus.in_address;
      bus.read_data_out              <= w_load;
      bus.misaligned_out             <= w_misaligned;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_mem_stage : directed self-checking bench for mem_stage        |
// | Revision     : 1.0                                               |
// +-----------------------------------------------------------------+
module tb_mem_stage;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_stage_if bus ();

  mem_stage #(.MEM_DEPTH_WORDS(1024)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".m2r"},  {31'd0, bus.mem_to_reg_out}, 32'd0);
    chk({tag, ".rw"},   {31'd0, bus.reg_write_out}, 32'd0);
    chk({tag, ".dst"},  {27'd0, bus.write_back_destination_out}, 32'd0);
    chk({tag, ".addr"}, bus.address_out, 32'd0);
    chk({tag, ".rd"},   bus.read_data_out, 32'd0);
    chk({tag, ".mis"},  {31'd0, bus.misaligned_out}, 32'd0);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic rw, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    bus.in_mem_read               = rd;
    bus.in_mem_write              = wr;
    bus.in_mem_to_reg             = rd;
    bus.in_reg_write              = rw;
    bus.in_size                   = sz;
    bus.in_unsigned               = uns;
    bus.in_write_back_destination = 5'd9;
    bus.in_address                = addr;
    bus.in_write_data             = wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_stall = 1'b0;
    bus.in_flush = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 32'h0, 32'h0);
    tick(); tick();
    rst = 1'b0;
    chk_zero("reset");

    // word store then load
    drive(0, 1, 0, 2'b00, 0, 32'h40, 32'hDEADBEEF); tick();
    drive(1, 0, 1, 2'b00, 0, 32'h40, 32'h0); tick();
    chk("lw40.rd", bus.read_data_out, 32'hDEADBEEF);
    chk("lw40.rw", {31'd0, bus.reg_write_out}, 32'd1);
    chk("lw40.addr", bus.address_out, 32'h40);
    chk("lw40.dst", {27'd0, bus.write_back_destination_out}, 32'd9);
    chk("lw40.m2r", {31'd0, bus.mem_to_reg_out}, 32'd1);

    // sub-word accesses
    drive(0, 1, 0, 2'b00, 0, 32'h20, 32'h80FF7F01); tick();
    drive(1, 0, 1, 2'b10, 0, 32'h20, 32'h0); tick();
    chk("lb20", bus.read_data_out, 32'hFFFFFF80);
    drive(1, 0, 1, 2'b10, 1, 32'h20, 32'h0); tick();
    chk("lbu20", bus.read_data_out, 32'h00000080);
    drive(1, 0, 1, 2'b01, 0, 32'h22, 32'h0); tick();
    chk("lh22", bus.read_data_out, 32'h00007F01);
    drive(1, 0, 1, 2'b01, 0, 32'h20, 32'h0); tick();
    chk("lh20", bus.read_data_out, 32'hFFFF80FF);
    drive(1, 0, 1, 2'b10, 1, 32'h23, 32'h0); tick();
    chk("lbu23", bus.read_data_out, 32'h00000001);
    drive(0, 1, 0, 2'b10, 0, 32'h21, 32'h123456AA); tick();
    drive(1, 0, 1, 2'b00, 0, 32'h20, 32'h0); tick();
    chk("sb21.lw20", bus.read_data_out, 32'h80AA7F01);

    // misaligned
    drive(1, 0, 1, 2'b00, 0, 32'h42, 32'h0); tick();
    chk("lw42.mis", {31'd0, bus.misaligned_out}, 32'd1);
    chk("lw42.rd", bus.read_data_out, 32'd0);
    chk("lw42.rw", {31'd0, bus.reg_write_out}, 32'd0);
    drive(0, 1, 0, 2'b01, 0, 32'h43, 32'h00001111); tick();
    chk("sh43.mis", {31'd0, bus.misaligned_out}, 32'd1);
    drive(1, 0, 1, 2'b11, 0, 32'h40, 32'h0); tick();
    chk("sh43.lw40", bus.read_data_out, 32'hDEADBEEF);
    chk("sz11.mis", {31'd0, bus.misaligned_out}, 32'd0);

    // reset mid-stream with a store pending
    drive(0, 1, 0, 2'b00, 0, 32'h10, 32'hCAFEF00D); tick();
    drive(0, 1, 1, 2'b00, 0, 32'h10, 32'h11111111);
    rst = 1'b1;
    #1;
    chk_zero("rst_async");
    tick();
    chk_zero("rst_held");
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 1, 2'b00, 0, 32'h10, 32'h0); tick();
    chk("rst.lw10", bus.read_data_out, 32'hCAFEF00D);
    chk("rst.rw", {31'd0, bus.reg_write_out}, 32'd1);

    // stall holds outputs and suppresses the store until it drops
    bus.in_stall = 1'b1;
    drive(0, 1, 0, 2'b00, 0, 32'h14, 32'h77777777);
    bus.in_address = 32'h10; tick(); tick();
    chk("stall.addr", bus.address_out, 32'h10);
    chk("stall.rd", bus.read_data_out, 32'hCAFEF00D);
    chk("stall.rw", {31'd0, bus.reg_write_out}, 32'd1);
    bus.in_stall = 1'b0; tick();
    chk("unstall.rd", bus.read_data_out, 32'hCAFEF00D);
    chk("unstall.rw", {31'd0, bus.reg_write_out}, 32'd0);
    drive(1, 0, 1, 2'b00, 0, 32'h10, 32'h0); tick();
    chk("unstall.lw10", bus.read_data_out, 32'h77777777);

    // flush beats stall, no store
    bus.in_stall = 1'b1;
    bus.in_flush = 1'b1;
    drive(1, 1, 1, 2'b00, 0, 32'h10, 32'h99999999); tick();
    chk_zero("flush");
    bus.in_stall = 1'b0;
    bus.in_flush = 1'b0;
    drive(1, 0, 1, 2'b00, 0, 32'h10, 32'h0); tick();
    chk("flush.lw10", bus.read_data_out, 32'h77777777);

    // address wrap and read-before-write on simultaneous read/write
    drive(0, 1, 0, 2'b00, 0, 32'h1000, 32'h12345678); tick();
    drive(1, 0, 1, 2'b00, 0, 32'h0, 32'h0); tick();
    chk("wrap.lw0", bus.read_data_out, 32'h12345678);
    drive(1, 1, 1, 2'b00, 0, 32'h0, 32'hA5A5A5A5); tick();
    chk("rw.old", bus.read_data_out, 32'h12345678);
    drive(1, 0, 1, 2'b00, 0, 32'h0, 32'h0); tick();
    chk("rw.new", bus.read_data_out, 32'hA5A5A5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
